// File: rtl/nios2_dbg_cmd_sysclk_bridge.sv
// Clock-domain half of the Nios II debug slave: synchronizes the virtual-JTAG update strobes and queues DR commands.
// Optional DBG_CMD_TIMESTAMP_EN adds a 16-bit free-running timestamp to each queued command (cmd_ts port).
module nios2_dbg_cmd_sysclk_bridge #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vs_udr,
    input  logic                     vs_uir,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [SR_W-1:0]          sr,
    input  logic                     cmd_ready,
    input  logic                     clr_ovf,
    output logic                     cmd_valid,
    output logic [IR_W-1:0]          cmd_ir,
    output logic [SR_W-1:0]          cmd_data,
    output logic                     cmd_action,
    output logic                     ir_update,
    output logic [IR_W-1:0]          ir_latched,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
`ifdef DBG_CMD_TIMESTAMP_EN
    ,
    output logic [15:0]              cmd_ts
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef DBG_CMD_TIMESTAMP_EN
    localparam int FW = 16 + IR_W + SR_W;
`else
    localparam int FW = IR_W + SR_W;
`endif

    logic [SYNC_STAGES-1:0] r_udrSync;
    logic [SYNC_STAGES-1:0] r_uirSync;
    logic                   r_udrHist;
    logic                   r_uirHist;
    logic                   w_udrPulse;
    logic                   w_uirPulse;

    logic [FW-1:0]          r_mem [DEPTH];
    logic [PW-1:0]          r_wrPtr;
    logic [PW-1:0]          r_rdPtr;
    logic [CW-1:0]          r_count;
    logic                   r_overflow;
    logic                   r_irUpdate;
    logic [IR_W-1:0]        r_irLatched;

    logic [FW-1:0]          w_entry;
    logic [FW-1:0]          w_head;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_write;

`ifdef DBG_CMD_TIMESTAMP_EN
    logic [15:0]            r_tsCnt;

    always_ff @(posedge clk) begin
        if (reset) r_tsCnt <= '0;
        else       r_tsCnt <= r_tsCnt + 16'd1;
    end

    assign w_entry = {r_tsCnt, ir_in, sr};
    assign cmd_ts  = w_head[FW-1 -: 16];
`else
    assign w_entry = {ir_in, sr};
`endif

    // Flops preset to 1 so a strobe already high at reset release never looks like a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_udrSync <= '1;
            r_uirSync <= '1;
            r_udrHist <= 1'b1;
            r_uirHist <= 1'b1;
        end else begin
            r_udrSync <= {r_udrSync[SYNC_STAGES-2:0], vs_udr};
            r_uirSync <= {r_uirSync[SYNC_STAGES-2:0], vs_uir};
            r_udrHist <= r_udrSync[SYNC_STAGES-1];
            r_uirHist <= r_uirSync[SYNC_STAGES-1];
        end
    end

    assign w_udrPulse = r_udrSync[SYNC_STAGES-1] & ~r_udrHist;
    assign w_uirPulse = r_uirSync[SYNC_STAGES-1] & ~r_uirHist;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = cmd_valid && cmd_ready;
    assign w_write = w_udrPulse && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_irUpdate  <= 1'b0;
            r_irLatched <= '0;
        end else begin
            if (w_write) begin
                r_mem[r_wrPtr] <= w_entry;
                r_wrPtr        <= r_wrPtr + PW'(1);
            end
            if (w_pop) r_rdPtr <= r_rdPtr + PW'(1);
            if (w_write && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_write && w_pop) r_count <= r_count - CW'(1);
            // A dropped push beats a simultaneous clear.
            if (w_udrPulse && !w_write) r_overflow <= 1'b1;
            else if (clr_ovf)           r_overflow <= 1'b0;
            r_irUpdate <= w_uirPulse;
            if (w_uirPulse) r_irLatched <= ir_in;
        end
    end

    assign w_head     = r_mem[r_rdPtr];
    assign cmd_valid  = (r_count != '0);
    assign cmd_data   = w_head[SR_W-1:0];
    assign cmd_ir     = w_head[SR_W +: IR_W];
    assign cmd_action = w_head[SR_W-1];
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign ir_update  = r_irUpdate;
    assign ir_latched = r_irLatched;

endmodule

// File: tb/tb_nios2_dbg_cmd_sysclk_bridge.sv
// Directed self-checking bench for nios2_dbg_cmd_sysclk_bridge (default parameters).
// Define DBG_CMD_TIMESTAMP_EN to also exercise the cmd_ts timestamp path.
module tb_nios2_dbg_cmd_sysclk_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        vs_udr;
    logic        vs_uir;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        cmd_ready;
    logic        clr_ovf;
    logic        cmd_valid;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_data;
    logic        cmd_action;
    logic        ir_update;
    logic [1:0]  ir_latched;
    logic [2:0]  fifo_count;
    logic        overflow;
`ifdef DBG_CMD_TIMESTAMP_EN
    logic [15:0] cmd_ts;
    logic [15:0] tsA;
`endif

    int vecCount = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    nios2_dbg_cmd_sysclk_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .vs_udr     (vs_udr),
        .vs_uir     (vs_uir),
        .ir_in      (ir_in),
        .sr         (sr),
        .cmd_ready  (cmd_ready),
        .clr_ovf    (clr_ovf),
        .cmd_valid  (cmd_valid),
        .cmd_ir     (cmd_ir),
        .cmd_data   (cmd_data),
        .cmd_action (cmd_action),
        .ir_update  (ir_update),
        .ir_latched (ir_latched),
        .fifo_count (fifo_count),
        .overflow   (overflow)
`ifdef DBG_CMD_TIMESTAMP_EN
        ,
        .cmd_ts     (cmd_ts)
`endif
    );

    // Advance n rising edges, leaving time 1 unit past the last one for sampling/driving.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One DR update: strobe high for three sampled edges (push on the third), then low long enough to re-arm.
    task automatic applyStimulus(input logic [1:0] irv, input logic [37:0] srv);
        ir_in  = irv;
        sr     = srv;
        vs_udr = 1'b1;
        step(3);
        vs_udr = 1'b0;
        step(3);
    endtask

    initial begin
        reset = 1'b1; vs_udr = 1'b1; vs_uir = 1'b0; ir_in = 2'b00; sr = '0;
        cmd_ready = 1'b0; clr_ovf = 1'b0;
        step(2);
        checkOutput("rst_valid", cmd_valid, 0);
        checkOutput("rst_count", fifo_count, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_irupd", ir_update, 0);
        checkOutput("rst_irlat", ir_latched, 0);

        // Strobe held high across reset release must not create an event.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checkOutput("held_valid", cmd_valid, 0);
        end
        checkOutput("held_count", fifo_count, 0);
        vs_udr = 1'b0;
        step(3);

        // Single command with immediate acceptance.
        ir_in = 2'b01; sr = 38'h20_0000_00A5; cmd_ready = 1'b1; vs_udr = 1'b1;
        step(1);
        checkOutput("lat_k", cmd_valid, 0);
        step(1);
        checkOutput("lat_k1", cmd_valid, 0);
        step(1);
        checkOutput("lat_k2", cmd_valid, 1);
        checkOutput("one_data", cmd_data, 38'h20_0000_00A5);
        checkOutput("one_ir", cmd_ir, 1);
        checkOutput("one_act", cmd_action, 1);
        checkOutput("one_count", fifo_count, 1);
        vs_udr = 1'b0;
        step(1);
        checkOutput("one_popped", cmd_valid, 0);
        checkOutput("one_count0", fifo_count, 0);
        step(3);
        checkOutput("one_nodup", cmd_valid, 0);

        // Overflow: five pushes into a four-deep FIFO.
        cmd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) applyStimulus(2'b00, 38'(i));
        checkOutput("ovf_count", fifo_count, 4);
        checkOutput("ovf_flag", overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drain_data", cmd_data, 64'(i));
            cmd_ready = 1'b1;
            step(1);
            cmd_ready = 1'b0;
        end
        checkOutput("drain_empty", cmd_valid, 0);
        checkOutput("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        checkOutput("ovf_clr", overflow, 0);

        // Full FIFO, push and pop on the same edge.
        for (int i = 1; i <= 4; i++) applyStimulus(2'b11, 38'(16 + i));
        checkOutput("full_count", fifo_count, 4);
        ir_in = 2'b11; sr = 38'h15; vs_udr = 1'b1;
        step(2);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        checkOutput("pp_count", fifo_count, 4);
        checkOutput("pp_ovf", overflow, 0);
        checkOutput("pp_head", cmd_data, 38'h12);
        vs_udr = 1'b0;
        step(3);
        for (int i = 2; i <= 5; i++) begin
            checkOutput("pp_order", cmd_data, 64'(16 + i));
            cmd_ready = 1'b1;
            step(1);
            cmd_ready = 1'b0;
        end
        checkOutput("pp_empty", fifo_count, 0);

        // IR and DR updates arriving together.
        ir_in = 2'b10; sr = 38'h1234; vs_uir = 1'b1; vs_udr = 1'b1;
        step(2);
        checkOutput("uir_early", ir_update, 0);
        step(1);
        checkOutput("uir_pulse", ir_update, 1);
        checkOutput("uir_lat", ir_latched, 2);
        checkOutput("both_valid", cmd_valid, 1);
        checkOutput("both_ir", cmd_ir, 2);
        checkOutput("both_data", cmd_data, 38'h1234);
        checkOutput("both_act", cmd_action, 0);
        step(1);
        checkOutput("uir_once", ir_update, 0);
        checkOutput("uir_hold", ir_latched, 2);
        vs_uir = 1'b0; vs_udr = 1'b0;
        step(3);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;

        // Reset with entries queued and strobes held high.
        for (int i = 0; i < 3; i++) applyStimulus(2'b01, 38'(32 + i));
        checkOutput("pre_rst_count", fifo_count, 3);
        vs_udr = 1'b1; vs_uir = 1'b1; reset = 1'b1;
        step(1);
        checkOutput("mid_rst_valid", cmd_valid, 0);
        checkOutput("mid_rst_count", fifo_count, 0);
        checkOutput("mid_rst_irlat", ir_latched, 0);
        reset = 1'b0;
        step(5);
        checkOutput("post_rst_count", fifo_count, 0);
        checkOutput("post_rst_irupd", ir_update, 0);
        vs_udr = 1'b0; vs_uir = 1'b0;
        step(3);

`ifdef DBG_CMD_TIMESTAMP_EN
        // Pushes land 7 edges apart.
        applyStimulus(2'b00, 38'h7);
        step(1);
        applyStimulus(2'b00, 38'h8);
        checkOutput("ts_count", fifo_count, 2);
        tsA = cmd_ts;
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        checkOutput("ts_delta", 16'(cmd_ts - tsA), 16'd7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
